// File: rtl/dmanu_seq_ctrl.sv
// Permutation-sequence controller: a small table of 12-lane source-select
// entries is walked from a first to a last index (wrapping back to the
// first) while input beats are registered alongside the current entry, so a
// downstream crossbar sees data and select aligned on the same cycle.
module dmanu_seq_ctrl #(
    parameter int NENT    = 8,
    parameter int AW      = 3,
    parameter int CW      = 16,
    parameter int DATA_W  = 8,
    localparam int LDTBL_W = 48
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_cfg_we,
    input  logic [AW-1:0]          i_cfg_addr,
    input  logic [LDTBL_W-1:0]     i_cfg_data,
    input  logic                   i_start,
    input  logic [AW-1:0]          i_first,
    input  logic [AW-1:0]          i_last,
    input  logic [CW-1:0]          i_len,
    input  logic                   i_abort,
    input  logic                   i_valid,
    input  logic [DATA_W*12-1:0]   i_indata,
    output logic                   o_ready,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [DATA_W*12-1:0]   o_indata,
    output logic [LDTBL_W-1:0]     o_seltbl,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_cfg_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [LDTBL_W-1:0]     r_tbl [NENT];

    logic [AW-1:0]          r_ptr;
    logic [AW-1:0]          r_first;
    logic [AW-1:0]          r_last;
    logic [CW-1:0]          r_len;
    logic [CW-1:0]          r_cnt;

    logic                   r_vld_p1;
    logic [DATA_W*12-1:0]   r_indata_p1;
    logic [LDTBL_W-1:0]     r_seltbl_p1;
    logic                   r_done;
    logic                   r_cfg_err;

    logic                   w_ready;
    logic                   w_accept;
    logic                   w_abort;
    logic                   w_drain_done;
    logic                   w_cfg_legal;
    logic                   w_cfg_wr;

    // Every lane must select one of the 12 inputs; nibbles 12..15 are invalid.
    function automatic logic f_tbl_legal(input logic [LDTBL_W-1:0] d);
        for (int k = 0; k < 12; k++) begin
            if (d[4*k +: 4] > 4'd11) begin
                return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    // Entry walk: last wraps back to first, otherwise natural modulo-NENT increment.
    function automatic logic [AW-1:0] f_ptr_next(input logic [AW-1:0] ptr,
                                                 input logic [AW-1:0] last,
                                                 input logic [AW-1:0] first);
        return (ptr == last) ? first : ptr + 1'b1;
    endfunction

    assign w_cfg_legal = f_tbl_legal(i_cfg_data);
    assign w_cfg_wr    = i_cfg_we && (r_state == S_IDLE) && w_cfg_legal;
    assign w_abort     = i_abort && (r_state != S_IDLE);
    assign w_accept    = (r_state == S_RUN) && w_ready && i_valid && !i_abort;

    // Next-state decode; abort overrides both beat acceptance and drain completion.
    always_comb begin
        w_state_nxt  = r_state;
        w_ready      = 1'b0;
        w_drain_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_ready = !r_vld_p1 || i_ready;
                if (i_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_ready && i_valid && ((r_cnt + CW'(1)) == r_len)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (i_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (!r_vld_p1 || i_ready) begin
                    w_state_nxt  = S_IDLE;
                    w_drain_done = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Run bookkeeping, output-valid tracking and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_first   <= '0;
            r_last    <= '0;
            r_len     <= '0;
            r_vld_p1  <= 1'b0;
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_done    <= w_drain_done;
            r_cfg_err <= i_cfg_we && ((r_state != S_IDLE) || !w_cfg_legal);
            if ((r_state == S_IDLE) && i_start) begin
                r_first <= i_first;
                r_last  <= i_last;
                r_len   <= (i_len == '0) ? CW'(1) : i_len;
                r_ptr   <= i_first;
                r_cnt   <= '0;
            end else if (w_accept) begin
                r_ptr <= f_ptr_next(r_ptr, r_last, r_first);
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_abort) begin
                r_vld_p1 <= 1'b0;
            end else if (w_accept) begin
                r_vld_p1 <= 1'b1;
            end else if (i_ready) begin
                r_vld_p1 <= 1'b0;
            end
        end
    end

    // Output beat register: data and its select entry are captured together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_indata_p1 <= '0;
            r_seltbl_p1 <= '0;
        end else if (w_accept) begin
            r_indata_p1 <= i_indata;
            r_seltbl_p1 <= r_tbl[r_ptr];
        end
    end

    // Permutation table; contents survive reset so a rerun needs no reload.
    always_ff @(posedge clk) begin
        if (w_cfg_wr) begin
            r_tbl[i_cfg_addr] <= i_cfg_data;
        end
    end

    assign o_ready   = w_ready;
    assign o_valid   = r_vld_p1;
    assign o_indata  = r_indata_p1;
    assign o_seltbl  = r_seltbl_p1;
    assign o_busy    = (r_state != S_IDLE);
    assign o_done    = r_done;
    assign o_cfg_err = r_cfg_err;

endmodule
